// File: rtl/fb_alu_dispatch.sv
// fb_alu_dispatch: RV32I decode/dispatch stage feeding the one-hot fb_alu.
// Decodes one instruction per cycle into a 19-bit one-hot ALU command with
// selected operands. The result is held in a single valid/ready output register.
module fb_alu_dispatch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [18:0] alu_control,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [4:0]  out_rd,
    output logic        illegal,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 19;
    localparam int unsigned REG_W  = 5;

    // One-hot bit positions of the ALU command
    localparam int unsigned B_ADD   = 0;
    localparam int unsigned B_SUB   = 1;
    localparam int unsigned B_SLL   = 2;
    localparam int unsigned B_SLT   = 3;
    localparam int unsigned B_SLTU  = 4;
    localparam int unsigned B_XOR   = 5;
    localparam int unsigned B_SRL   = 6;
    localparam int unsigned B_SRA   = 7;
    localparam int unsigned B_OR    = 8;
    localparam int unsigned B_AND   = 9;
    localparam int unsigned B_PASS  = 10;
    localparam int unsigned B_BEQ   = 11;
    localparam int unsigned B_BNE   = 12;
    localparam int unsigned B_BLT   = 13;
    localparam int unsigned B_BGE   = 14;
    localparam int unsigned B_BLTU  = 15;
    localparam int unsigned B_BGEU  = 16;
    localparam int unsigned B_CSRRW = 17;
    localparam int unsigned B_CSRRS = 18;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   shamt;
    logic [XLEN-1:0]   csr_addr;

    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_op1;
    logic [XLEN-1:0]   dec_op2;
    logic [REG_W-1:0]  dec_rd;
    logic              dec_ill;
    logic              load;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u    = {in_instr[31:12], 12'b0};
    assign shamt    = XLEN'(in_instr[24:20]);
    assign csr_addr = XLEN'(in_instr[31:20]);

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Decode the incoming instruction into command, operands and destination
    always_comb begin
        dec_ctrl = '0;
        dec_op1  = '0;
        dec_op2  = '0;
        dec_rd   = in_instr[11:7];
        dec_ill  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op1 = rs1_data;
                dec_op2 = rs2_data;
                if (funct7 == F7_ALT) begin
                    // Only SUB and SRA use the alternate funct7
                    case (funct3)
                        3'b000:  dec_ctrl[B_SUB] = 1'b1;
                        3'b101:  dec_ctrl[B_SRA] = 1'b1;
                        default: dec_ill = 1'b1;
                    endcase
                end else if (funct7 == F7_ZERO) begin
                    case (funct3)
                        3'b000:  dec_ctrl[B_ADD]  = 1'b1;
                        3'b001:  dec_ctrl[B_SLL]  = 1'b1;
                        3'b010:  dec_ctrl[B_SLT]  = 1'b1;
                        3'b011:  dec_ctrl[B_SLTU] = 1'b1;
                        3'b100:  dec_ctrl[B_XOR]  = 1'b1;
                        3'b101:  dec_ctrl[B_SRL]  = 1'b1;
                        3'b110:  dec_ctrl[B_OR]   = 1'b1;
                        default: dec_ctrl[B_AND]  = 1'b1;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_op1 = rs1_data;
                dec_op2 = imm_i;
                case (funct3)
                    3'b000: dec_ctrl[B_ADD]  = 1'b1;
                    3'b010: dec_ctrl[B_SLT]  = 1'b1;
                    3'b011: dec_ctrl[B_SLTU] = 1'b1;
                    3'b100: dec_ctrl[B_XOR]  = 1'b1;
                    3'b110: dec_ctrl[B_OR]   = 1'b1;
                    3'b111: dec_ctrl[B_AND]  = 1'b1;
                    3'b001: begin
                        dec_op2 = shamt;
                        if (funct7 == F7_ZERO) dec_ctrl[B_SLL] = 1'b1;
                        else                   dec_ill = 1'b1;
                    end
                    default: begin
                        dec_op2 = shamt;
                        if (funct7 == F7_ZERO)     dec_ctrl[B_SRL] = 1'b1;
                        else if (funct7 == F7_ALT) dec_ctrl[B_SRA] = 1'b1;
                        else                       dec_ill = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_op2          = imm_u;
                dec_ctrl[B_PASS] = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op1         = in_pc;
                dec_op2         = imm_u;
                dec_ctrl[B_ADD] = 1'b1;
            end
            OPC_BRANCH: begin
                dec_op1 = rs1_data;
                dec_op2 = rs2_data;
                dec_rd  = '0;
                case (funct3)
                    3'b000:  dec_ctrl[B_BEQ]  = 1'b1;
                    3'b001:  dec_ctrl[B_BNE]  = 1'b1;
                    3'b100:  dec_ctrl[B_BLT]  = 1'b1;
                    3'b101:  dec_ctrl[B_BGE]  = 1'b1;
                    3'b110:  dec_ctrl[B_BLTU] = 1'b1;
                    3'b111:  dec_ctrl[B_BGEU] = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                dec_op1 = rs1_data;
                dec_op2 = csr_addr;
                case (funct3)
                    3'b001:  dec_ctrl[B_CSRRW] = 1'b1;
                    3'b010:  dec_ctrl[B_CSRRS] = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Unsupported instructions dispatch as a trap with all payload cleared
        if (dec_ill) begin
            dec_ctrl = '0;
            dec_op1  = '0;
            dec_op2  = '0;
            dec_rd   = '0;
        end
    end

    // Output register: load on handshake, drop valid when consumed with no refill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= '0;
            op1         <= '0;
            op2         <= '0;
            out_rd      <= '0;
            illegal     <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            alu_control <= dec_ctrl;
            op1         <= dec_op1;
            op2         <= dec_op2;
            out_rd      <= dec_rd;
            illegal     <= dec_ill;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_alu_dispatch.sv
// Bench for fb_alu_dispatch: directed literal cases plus randomized traffic
// compared every cycle against a behavioural one-entry output model.
module tb_fb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [18:0] alu_control;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  out_rd;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    fb_alu_dispatch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_control(alu_control),
        .op1(op1), .op2(op2), .out_rd(out_rd), .illegal(illegal),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: pick the ALU operation index from the ISA tables
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int   idx;
        int   rop[8];
        int   brn[8];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        rop = '{0, 2, 3, 4, 5, 6, 8, 9};
        brn = '{11, 12, -1, -1, 13, 14, 15, 16};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        idx = -1;
        e.a = 0;
        e.b = 0;
        e.rd = ins[11:7];
        if (opc == 7'h33) begin
            e.a = r1; e.b = r2;
            if (f7 == 7'h00) idx = rop[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) idx = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) idx = 7;
        end else if (opc == 7'h13) begin
            e.a = r1;
            e.b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = {27'd0, ins[24:20]};
                if (f7 == 7'h00) idx = rop[f3];
                else if (f7 == 7'h20 && f3 == 3'd5) idx = 7;
            end else begin
                idx = rop[f3];
            end
        end else if (opc == 7'h37) begin
            idx = 10; e.b = {ins[31:12], 12'h000};
        end else if (opc == 7'h17) begin
            idx = 0; e.a = pc; e.b = {ins[31:12], 12'h000};
        end else if (opc == 7'h63) begin
            idx = brn[f3]; e.a = r1; e.b = r2; e.rd = 0;
        end else if (opc == 7'h73) begin
            e.a = r1; e.b = {20'd0, ins[31:20]};
            if (f3 == 3'd1) idx = 17;
            else if (f3 == 3'd2) idx = 18;
        end
        if (idx < 0) begin
            e = '0;
            e.ill = 1'b1;
        end else begin
            e.ctrl = 19'd1 << idx;
            e.ill  = 1'b0;
        end
        return e;
    endfunction

    // Behavioural model of the single output slot
    exp_t m;
    logic m_valid = 1'b0;
    logic started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m       = '0;
            started = 1'b1;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m       = ref_dec(in_instr, in_pc, rs1_data, rs2_data);
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            chk("rs1_addr", 64'(rs1_addr), 64'(in_instr[19:15]));
            chk("rs2_addr", 64'(rs2_addr), 64'(in_instr[24:20]));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("alu_control", 64'(alu_control), 64'(m.ctrl));
            chk("op1", 64'(op1), 64'(m.a));
            chk("op2", 64'(op2), 64'(m.b));
            chk("out_rd", 64'(out_rd), 64'(m.rd));
            chk("illegal", 64'(illegal), 64'(m.ill));
        end
    end

    // Directed load with hand-computed expectations, one cycle latency
    task automatic dir(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [18:0] ec, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [4:0] erd, input logic eill);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        rs1_data  = r1;
        rs2_data  = r2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, ".valid"}, 64'(out_valid), 64'(1));
        chk({nm, ".ctrl"}, 64'(alu_control), 64'(ec));
        chk({nm, ".op1"}, 64'(op1), 64'(e1));
        chk({nm, ".op2"}, 64'(op2), 64'(e2));
        chk({nm, ".rd"}, 64'(out_rd), 64'(erd));
        chk({nm, ".ill"}, 64'(illegal), 64'(eill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opcs[7];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h73, 7'h00};
        ins = $urandom;
        ins[6:0] = opcs[$urandom_range(0, 6)];
        if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
        case ($urandom_range(0, 3))
            0, 2:    ins[31:25] = 7'h00;
            1:       ins[31:25] = 7'h20;
            default: ins[31:25] = 7'($urandom);
        endcase
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'(1));
        chk("reset.valid", 64'(out_valid), 64'(0));
        chk("reset.ctrl", 64'(alu_control), 64'(0));
        chk("reset.ill", 64'(illegal), 64'(0));
        rst_n = 1'b1;

        dir("add",   32'h002081B3, 32'h0,   32'd5,  32'd7,  19'h00001, 32'd5,  32'd7,        5'd3, 1'b0);
        dir("sub",   32'h402081B3, 32'h0,   32'd5,  32'd7,  19'h00002, 32'd5,  32'd7,        5'd3, 1'b0);
        dir("srai",  32'h4030D093, 32'h0,   32'h80, 32'd9,  19'h00080, 32'h80, 32'd3,        5'd1, 1'b0);
        dir("addi",  32'hFFF00093, 32'h0,   32'd0,  32'd9,  19'h00001, 32'd0,  32'hFFFFFFFF, 5'd1, 1'b0);
        dir("lui",   32'h123450B7, 32'h0,   32'd4,  32'd9,  19'h00400, 32'd0,  32'h12345000, 5'd1, 1'b0);
        dir("auipc", 32'h00001097, 32'h100, 32'd4,  32'd9,  19'h00001, 32'h100, 32'h1000,    5'd1, 1'b0);
        dir("beq",   32'h00208463, 32'h0,   32'd11, 32'd12, 19'h00800, 32'd11, 32'd12,       5'd0, 1'b0);
        dir("csrrw", 32'h30009073, 32'h0,   32'd13, 32'd14, 19'h20000, 32'd13, 32'h300,      5'd0, 1'b0);
        dir("zero",  32'h00000000, 32'h0,   32'd13, 32'd14, 19'h00000, 32'd0,  32'd0,        5'd0, 1'b1);
        dir("br010", 32'h0020A463, 32'h0,   32'd13, 32'd14, 19'h00000, 32'd0,  32'd0,        5'd0, 1'b1);
        dir("add2",  32'h002081B3, 32'h0,   32'd5,  32'd7,  19'h00001, 32'd5,  32'd7,        5'd3, 1'b0);

        // Backpressure: a pending SUB must not be sampled while stalled
        out_ready = 1'b0;
        in_instr  = 32'h402081B3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall.in_ready", 64'(in_ready), 64'(0));
            chk("stall.ctrl", 64'(alu_control), 64'(19'h00001));
            chk("stall.valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release.ctrl", 64'(alu_control), 64'(19'h00002));
        chk("release.valid", 64'(out_valid), 64'(1));

        // Reset while holding a valid result
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.ctrl", 64'(alu_control), 64'(0));
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;

        // Randomized traffic with random handshakes and rare resets
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
